// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: RV32I opcode/func3 encodings,
// FSM state, ALU operation select, byte-enable patterns and the context a
// memory access carries while the request is outstanding.
package exec_pkg;

    localparam int unsigned LANE_W = 2;     // byte-lane index width of a 32-bit word
    localparam int unsigned BE_W   = 4;     // byte-enable pattern width

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // OP / OP-IMM func3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch func3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load / store func3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Byte-enable patterns before lane shifting
    localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
    localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEM  = 1'b1
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

    // Context held for the duration of an outstanding memory access
    typedef struct packed {
        logic              is_load;
        logic              wen;
        logic [4:0]        rd;
        logic [2:0]        func3;
        logic [LANE_W-1:0] lane;
    } mem_ctx_t;

    // func3[1:0] encodes access size for both loads and stores (00 B, 01 H, 10 W)
    function automatic logic is_misaligned(input logic [2:0] func3,
                                           input logic [LANE_W-1:0] lane);
        return ((func3[1:0] == 2'b01) && lane[0]) ||
               ((func3[1:0] == 2'b10) && (lane != '0));
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU and branch comparator.
//   alu_op      operation select for result_c
//   br_func3    branch condition (BEQ..BGEU); other codes never take
//   a, b        operands (shift amount is b[log2(XLEN)-1:0])
//   result_c    ALU result
//   br_taken_c  branch condition of a against b holds
module exec_alu
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  alu_op_e         alu_op,
    input  logic [2:0]      br_func3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result_c,
    output logic            br_taken_c
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    logic           eq, lt, ltu;

    assign shamt = b[SHW-1:0];
    assign eq    = (a == b);
    assign lt    = ($signed(a) < $signed(b));
    assign ltu   = (a < b);

    // Arithmetic / logic result
    always_comb begin
        result_c = '0;
        case (alu_op)
            ALU_ADD:  result_c = a + b;
            ALU_SUB:  result_c = a - b;
            ALU_SLL:  result_c = a << shamt;
            ALU_SLT:  result_c = XLEN'(lt);
            ALU_SLTU: result_c = XLEN'(ltu);
            ALU_XOR:  result_c = a ^ b;
            ALU_SRL:  result_c = a >> shamt;
            ALU_SRA:  result_c = XLEN'($signed(a) >>> shamt);
            ALU_OR:   result_c = a | b;
            ALU_AND:  result_c = a & b;
            default:  result_c = '0;
        endcase
    end

    // Branch condition
    always_comb begin
        br_taken_c = 1'b0;
        case (br_func3)
            F3_BEQ:  br_taken_c = eq;
            F3_BNE:  br_taken_c = !eq;
            F3_BLT:  br_taken_c = lt;
            F3_BGE:  br_taken_c = !lt;
            F3_BLTU: br_taken_c = ltu;
            F3_BGEU: br_taken_c = !ltu;
            default: br_taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// Registered RV32I execute stage with a load/store request/ack engine.
// Non-memory instructions complete in the cycle after accept; loads and
// stores hold a request until acknowledged or timed out, stalling decode.
//   clk, rst                 clock, async active-high reset
//   valid_in / ready_out     decode handshake (ready only while IDLE)
//   instr_*, op*, imm_in,    decoded instruction and operands
//   jump_op*, write_addr_in,
//   wen_in
//   valid_out, write_*,      one-cycle result pulse to writeback / PC logic
//   wen_out, jump_*,
//   fault_out
//   mem_*                    data-memory request/ack port
module exec_unit
    import exec_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [XLEN-1:0]   instr_addr_in,
    input  logic [31:0]       instr_in,
    input  logic [4:0]        write_addr_in,
    input  logic              wen_in,
    input  logic [XLEN-1:0]   op1_in,
    input  logic [XLEN-1:0]   op2_in,
    input  logic [XLEN-1:0]   imm_in,
    input  logic [XLEN-1:0]   jump_op1_in,
    input  logic [XLEN-1:0]   jump_op2_in,
    output logic              valid_out,
    output logic [4:0]        write_addr_out,
    output logic [XLEN-1:0]   write_data_out,
    output logic              wen_out,
    output logic [XLEN-1:0]   jump_addr_out,
    output logic              jump_flag_out,
    output logic              fault_out,
    output logic              mem_req_out,
    output logic              mem_we_out,
    output logic [XLEN-1:0]   mem_addr_out,
    output logic [XLEN-1:0]   mem_wdata_out,
    output logic [XLEN/8-1:0] mem_be_out,
    input  logic              mem_ack_in,
    input  logic [XLEN-1:0]   mem_rdata_in
);

    localparam int unsigned MBE_W = XLEN / 8;
    localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    state_e     state;
    mem_ctx_t   ctx;
    logic [CNT_W-1:0] tmo_cnt;

    logic [6:0] opcode_c;
    logic [2:0] func3_c;
    logic       f7_alt_c;
    logic       unused_ok;

    alu_op_e         alu_op_c;
    logic [XLEN-1:0] alu_res_c;
    logic            br_taken_c;

    logic [XLEN-1:0] jump_sum_c;
    logic [XLEN-1:0] nm_data_c;
    logic            nm_wr_c;
    logic            jflag_c;
    logic [XLEN-1:0] jaddr_c;
    logic            is_mem_c;
    logic            is_store_c;
    logic [XLEN-1:0] maddr_c;
    logic [LANE_W-1:0] lane_c;
    logic            misalign_c;
    logic [BE_W-1:0] be_base_c;
    logic [MBE_W-1:0] be_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] rshift_c;
    logic [XLEN-1:0] load_data_c;

    assign opcode_c  = instr_in[6:0];
    assign func3_c   = instr_in[14:12];
    assign f7_alt_c  = instr_in[30];
    assign unused_ok = ^{instr_in[31], instr_in[29:15], instr_in[11:7]};

    assign jump_sum_c = jump_op1_in + jump_op2_in;

    // ALU operation select from func3 / func7[5]
    always_comb begin
        alu_op_c = ALU_ADD;
        case (func3_c)
            F3_ADD:  alu_op_c = (opcode_c == OPC_OP && f7_alt_c) ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_op_c = ALU_SLL;
            F3_SLT:  alu_op_c = ALU_SLT;
            F3_SLTU: alu_op_c = ALU_SLTU;
            F3_XOR:  alu_op_c = ALU_XOR;
            F3_SR:   alu_op_c = f7_alt_c ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_op_c = ALU_OR;
            F3_AND:  alu_op_c = ALU_AND;
            default: alu_op_c = ALU_ADD;
        endcase
    end

    exec_alu #(.XLEN(XLEN)) u_alu (
        .alu_op     (alu_op_c),
        .br_func3   (func3_c),
        .a          (op1_in),
        .b          (op2_in),
        .result_c   (alu_res_c),
        .br_taken_c (br_taken_c)
    );

    // Instruction class decode and single-cycle results
    always_comb begin
        nm_data_c  = '0;
        nm_wr_c    = 1'b0;
        jflag_c    = 1'b0;
        jaddr_c    = '0;
        is_mem_c   = 1'b0;
        is_store_c = 1'b0;
        case (opcode_c)
            OPC_OP, OPC_OP_IMM: begin
                nm_wr_c   = 1'b1;
                nm_data_c = alu_res_c;
            end
            OPC_LUI: begin
                nm_wr_c   = 1'b1;
                nm_data_c = op1_in;
            end
            OPC_AUIPC: begin
                nm_wr_c   = 1'b1;
                nm_data_c = instr_addr_in + op1_in;
            end
            OPC_JAL: begin
                nm_wr_c   = 1'b1;
                nm_data_c = instr_addr_in + XLEN'(4);
                jflag_c   = 1'b1;
                jaddr_c   = jump_sum_c;
            end
            OPC_JALR: begin
                if (func3_c == 3'b000) begin
                    nm_wr_c   = 1'b1;
                    nm_data_c = instr_addr_in + XLEN'(4);
                    jflag_c   = 1'b1;
                    jaddr_c   = jump_sum_c & ~XLEN'(1);
                end
            end
            OPC_BRANCH: begin
                // unsupported branch func3 never take, leaving a plain valid pulse
                if (br_taken_c) begin
                    jflag_c = 1'b1;
                    jaddr_c = jump_sum_c;
                end
            end
            OPC_LOAD: begin
                case (func3_c)
                    F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: is_mem_c = 1'b1;
                    default: is_mem_c = 1'b0;
                endcase
            end
            OPC_STORE: begin
                case (func3_c)
                    F3_SB, F3_SH, F3_SW: begin
                        is_mem_c   = 1'b1;
                        is_store_c = 1'b1;
                    end
                    default: is_mem_c = 1'b0;
                endcase
            end
            default: nm_data_c = '0;
        endcase
    end

    // Address, lane alignment and byte enables for a new access
    always_comb begin
        maddr_c = is_store_c ? (op1_in + imm_in) : (op1_in + op2_in);
        lane_c  = maddr_c[LANE_W-1:0];
        case (func3_c[1:0])
            2'b00:   be_base_c = BE_BYTE;
            2'b01:   be_base_c = BE_HALF;
            default: be_base_c = BE_WORD;
        endcase
        be_c       = MBE_W'(be_base_c) << lane_c;
        wdata_c    = op2_in << {lane_c, 3'b000};
        misalign_c = (ALIGN_CHECK != 0) && is_mem_c && is_misaligned(func3_c, lane_c);
    end

    // Load data extraction from the returned aligned word
    always_comb begin
        rshift_c = mem_rdata_in >> {ctx.lane, 3'b000};
        case (ctx.func3)
            F3_LB:   load_data_c = {{(XLEN-8){rshift_c[7]}}, rshift_c[7:0]};
            F3_LH:   load_data_c = {{(XLEN-16){rshift_c[15]}}, rshift_c[15:0]};
            F3_LBU:  load_data_c = {{(XLEN-8){1'b0}}, rshift_c[7:0]};
            F3_LHU:  load_data_c = {{(XLEN-16){1'b0}}, rshift_c[15:0]};
            default: load_data_c = rshift_c;
        endcase
    end

    // FSM, timeout counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            ctx            <= '0;
            tmo_cnt        <= '0;
            ready_out      <= 1'b0;
            valid_out      <= 1'b0;
            write_addr_out <= '0;
            write_data_out <= '0;
            wen_out        <= 1'b0;
            jump_addr_out  <= '0;
            jump_flag_out  <= 1'b0;
            fault_out      <= 1'b0;
            mem_req_out    <= 1'b0;
            mem_we_out     <= 1'b0;
            mem_addr_out   <= '0;
            mem_wdata_out  <= '0;
            mem_be_out     <= '0;
        end else begin
            // result fields are pulses; cleared unless something completes
            valid_out      <= 1'b0;
            write_addr_out <= '0;
            write_data_out <= '0;
            wen_out        <= 1'b0;
            jump_addr_out  <= '0;
            jump_flag_out  <= 1'b0;
            fault_out      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ready_out <= 1'b1;
                    if (valid_in && ready_out) begin
                        if (is_mem_c && !misalign_c) begin
                            state         <= ST_MEM;
                            ready_out     <= 1'b0;
                            tmo_cnt       <= '0;
                            mem_req_out   <= 1'b1;
                            mem_we_out    <= is_store_c;
                            mem_addr_out  <= maddr_c;
                            mem_wdata_out <= is_store_c ? wdata_c : '0;
                            mem_be_out    <= be_c;
                            ctx.is_load   <= !is_store_c;
                            ctx.wen       <= wen_in;
                            ctx.rd        <= write_addr_in;
                            ctx.func3     <= func3_c;
                            ctx.lane      <= lane_c;
                        end else begin
                            valid_out      <= 1'b1;
                            write_addr_out <= write_addr_in;
                            write_data_out <= nm_data_c;
                            wen_out        <= wen_in && nm_wr_c && (write_addr_in != 5'd0);
                            jump_flag_out  <= jflag_c;
                            jump_addr_out  <= jaddr_c;
                            fault_out      <= misalign_c;
                        end
                    end
                end
                ST_MEM: begin
                    // an ack in the final request cycle still wins over the timeout
                    if (mem_ack_in) begin
                        state          <= ST_IDLE;
                        ready_out      <= 1'b1;
                        mem_req_out    <= 1'b0;
                        mem_we_out     <= 1'b0;
                        mem_addr_out   <= '0;
                        mem_wdata_out  <= '0;
                        mem_be_out     <= '0;
                        valid_out      <= 1'b1;
                        write_addr_out <= ctx.rd;
                        write_data_out <= ctx.is_load ? load_data_c : '0;
                        wen_out        <= ctx.is_load && ctx.wen && (ctx.rd != 5'd0);
                    end else if ((MEM_TIMEOUT != 0) &&
                                 (tmo_cnt == CNT_W'(MEM_TIMEOUT - 1))) begin
                        state          <= ST_IDLE;
                        ready_out      <= 1'b1;
                        mem_req_out    <= 1'b0;
                        mem_we_out     <= 1'b0;
                        mem_addr_out   <= '0;
                        mem_wdata_out  <= '0;
                        mem_be_out     <= '0;
                        valid_out      <= 1'b1;
                        write_addr_out <= ctx.rd;
                        fault_out      <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit (MEM_TIMEOUT=4, ALIGN_CHECK=1).
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] instr_addr_in, instr_in;
    logic [4:0]  write_addr_in;
    logic        wen_in;
    logic [31:0] op1_in, op2_in, imm_in, jump_op1_in, jump_op2_in;
    logic        valid_out;
    logic [4:0]  write_addr_out;
    logic [31:0] write_data_out;
    logic        wen_out;
    logic [31:0] jump_addr_out;
    logic        jump_flag_out;
    logic        fault_out;
    logic        mem_req_out, mem_we_out;
    logic [31:0] mem_addr_out, mem_wdata_out;
    logic [3:0]  mem_be_out;
    logic        mem_ack_in;
    logic [31:0] mem_rdata_in;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exec_unit #(.XLEN(32), .MEM_TIMEOUT(4), .ALIGN_CHECK(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .ready_out      (ready_out),
        .instr_addr_in  (instr_addr_in),
        .instr_in       (instr_in),
        .write_addr_in  (write_addr_in),
        .wen_in         (wen_in),
        .op1_in         (op1_in),
        .op2_in         (op2_in),
        .imm_in         (imm_in),
        .jump_op1_in    (jump_op1_in),
        .jump_op2_in    (jump_op2_in),
        .valid_out      (valid_out),
        .write_addr_out (write_addr_out),
        .write_data_out (write_data_out),
        .wen_out        (wen_out),
        .jump_addr_out  (jump_addr_out),
        .jump_flag_out  (jump_flag_out),
        .fault_out      (fault_out),
        .mem_req_out    (mem_req_out),
        .mem_we_out     (mem_we_out),
        .mem_addr_out   (mem_addr_out),
        .mem_wdata_out  (mem_wdata_out),
        .mem_be_out     (mem_be_out),
        .mem_ack_in     (mem_ack_in),
        .mem_rdata_in   (mem_rdata_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {func7, rs2, rs1, func3, rd, opcode} with register fields zeroed
    function automatic logic [31:0] enc(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [6:0] f7);
        return {f7, 10'b0, f3, 5'b0, opc};
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] j1,
                         input logic [31:0] j2, input logic [4:0] rd,
                         input logic wen);
        valid_in      = 1'b1;
        instr_in      = instr;
        instr_addr_in = pc;
        op1_in        = a;
        op2_in        = b;
        imm_in        = imm;
        jump_op1_in   = j1;
        jump_op2_in   = j2;
        write_addr_in = rd;
        wen_in        = wen;
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0; instr_in = '0; instr_addr_in = '0; write_addr_in = '0;
        wen_in = 1'b0; op1_in = '0; op2_in = '0; imm_in = '0;
        jump_op1_in = '0; jump_op2_in = '0; mem_ack_in = 1'b0; mem_rdata_in = '0;

        // reset state
        tick(); tick();
        chk("rst_ready", 32'(ready_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_req",   32'(mem_req_out), 32'd0);
        rst = 1'b0;
        chk("rel_ready_low", 32'(ready_out), 32'd0);
        tick();
        chk("rel_ready_high", 32'(ready_out), 32'd1);

        // ADDI then SUB back to back
        drive(enc(7'b0010011, 3'b000, 7'b0), 32'h0, 32'd5, 32'hFFFF_FFF9, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1);
        tick();
        chk("addi_valid", 32'(valid_out), 32'd1);
        chk("addi_data",  write_data_out, 32'hFFFF_FFFE);
        chk("addi_wen",   32'(wen_out), 32'd1);
        chk("addi_rd",    32'(write_addr_out), 32'd3);
        drive(enc(7'b0110011, 3'b000, 7'b0100000), 32'h0, 32'd5, 32'd7, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1);
        tick();
        chk("sub_data", write_data_out, 32'hFFFF_FFFE);
        chk("sub_rd",   32'(write_addr_out), 32'd4);

        // SRA / SRL
        drive(enc(7'b0110011, 3'b101, 7'b0100000), 32'h0, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1);
        tick();
        chk("sra_data", write_data_out, 32'hF800_0000);
        drive(enc(7'b0110011, 3'b101, 7'b0), 32'h0, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1);
        tick();
        chk("srl_data", write_data_out, 32'h0800_0000);
        valid_in = 1'b0;
        tick();
        chk("pulse_end", 32'(valid_out), 32'd0);

        // BLT taken, BLTU not taken
        drive(enc(7'b1100011, 3'b100, 7'b0), 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h100, 32'h20, 5'd5, 1'b1);
        tick();
        chk("blt_flag", 32'(jump_flag_out), 32'd1);
        chk("blt_addr", jump_addr_out, 32'h120);
        chk("blt_wen",  32'(wen_out), 32'd0);
        drive(enc(7'b1100011, 3'b110, 7'b0), 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h100, 32'h20, 5'd5, 1'b1);
        tick();
        chk("bltu_flag",  32'(jump_flag_out), 32'd0);
        chk("bltu_addr",  jump_addr_out, 32'h0);
        chk("bltu_valid", 32'(valid_out), 32'd1);

        // JAL rd=0, JALR bit-0 clear
        drive(enc(7'b1101111, 3'b000, 7'b0), 32'h400, 32'h0, 32'h0, 32'h0, 32'h400, 32'h10, 5'd0, 1'b1);
        tick();
        chk("jal_flag", 32'(jump_flag_out), 32'd1);
        chk("jal_addr", jump_addr_out, 32'h410);
        chk("jal_wen",  32'(wen_out), 32'd0);
        drive(enc(7'b1100111, 3'b000, 7'b0), 32'h200, 32'h0, 32'h0, 32'h0, 32'h100, 32'h3, 5'd1, 1'b1);
        tick();
        chk("jalr_addr", jump_addr_out, 32'h102);
        chk("jalr_data", write_data_out, 32'h204);
        chk("jalr_wen",  32'(wen_out), 32'd1);

        // LUI / AUIPC / unsupported opcode
        drive(enc(7'b0110111, 3'b000, 7'b0), 32'h0, 32'h1234_5000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd6, 1'b1);
        tick();
        chk("lui_data", write_data_out, 32'h1234_5000);
        drive(enc(7'b0010111, 3'b000, 7'b0), 32'h400, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd6, 1'b1);
        tick();
        chk("auipc_data", write_data_out, 32'h1400);
        drive(32'h0000_007F, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1);
        tick();
        valid_in = 1'b0;
        chk("unsup_valid", 32'(valid_out), 32'd1);
        chk("unsup_wen",   32'(wen_out), 32'd0);
        chk("unsup_req",   32'(mem_req_out), 32'd0);

        // LB at 0x1003, ack in the fourth request cycle
        drive(enc(7'b0000011, 3'b000, 7'b0), 32'h0, 32'h1000, 32'd3, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1);
        tick();
        valid_in = 1'b0;
        chk("lb_req",   32'(mem_req_out), 32'd1);
        chk("lb_we",    32'(mem_we_out), 32'd0);
        chk("lb_addr",  mem_addr_out, 32'h1003);
        chk("lb_ready", 32'(ready_out), 32'd0);
        tick();
        tick();
        chk("lb_wait_ready", 32'(ready_out), 32'd0);
        tick();
        mem_ack_in = 1'b1; mem_rdata_in = 32'h8011_2233;
        chk("lb_ack_req", 32'(mem_req_out), 32'd1);
        tick();
        mem_ack_in = 1'b0;
        chk("lb_valid", 32'(valid_out), 32'd1);
        chk("lb_data",  write_data_out, 32'hFFFF_FF80);
        chk("lb_wen",   32'(wen_out), 32'd1);
        chk("lb_rd",    32'(write_addr_out), 32'd7);
        chk("lb_req_drop", 32'(mem_req_out), 32'd0);
        chk("lb_ready_back", 32'(ready_out), 32'd1);

        // SH at 0x2002 with immediate ack
        drive(enc(7'b0100011, 3'b001, 7'b0), 32'h0, 32'h2000, 32'h0000_ABCD, 32'd2, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        valid_in = 1'b0;
        chk("sh_req",   32'(mem_req_out), 32'd1);
        chk("sh_we",    32'(mem_we_out), 32'd1);
        chk("sh_addr",  mem_addr_out, 32'h2002);
        chk("sh_be",    32'(mem_be_out), 32'h0000_000C);
        chk("sh_wdata", mem_wdata_out, 32'hABCD_0000);
        mem_ack_in = 1'b1;
        tick();
        mem_ack_in = 1'b0;
        chk("sh_valid", 32'(valid_out), 32'd1);
        chk("sh_wen",   32'(wen_out), 32'd0);
        chk("sh_req_drop", 32'(mem_req_out), 32'd0);

        // ack while idle is ignored
        mem_ack_in = 1'b1;
        tick();
        mem_ack_in = 1'b0;
        chk("stray_ack_valid", 32'(valid_out), 32'd0);

        // SW at 0x2001 faults, no request
        drive(enc(7'b0100011, 3'b010, 7'b0), 32'h0, 32'h2000, 32'h1111_2222, 32'd1, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        valid_in = 1'b0;
        chk("sw_fault", 32'(fault_out), 32'd1);
        chk("sw_req",   32'(mem_req_out), 32'd0);
        chk("sw_ready", 32'(ready_out), 32'd1);
        tick();
        chk("sw_fault_pulse", 32'(fault_out), 32'd0);

        // LW never acknowledged: timeout after 4 request cycles
        drive(enc(7'b0000011, 3'b010, 7'b0), 32'h0, 32'h3000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd8, 1'b1);
        tick();
        valid_in = 1'b0;
        tick(); tick(); tick();
        chk("tmo_req_last", 32'(mem_req_out), 32'd1);
        chk("tmo_no_fault_yet", 32'(fault_out), 32'd0);
        tick();
        chk("tmo_req_drop", 32'(mem_req_out), 32'd0);
        chk("tmo_fault", 32'(fault_out), 32'd1);
        chk("tmo_valid", 32'(valid_out), 32'd1);
        chk("tmo_wen",   32'(wen_out), 32'd0);

        // reset during MEM drops everything asynchronously
        drive(enc(7'b0000011, 3'b010, 7'b0), 32'h0, 32'h4000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1);
        tick();
        valid_in = 1'b0;
        chk("mrst_req_before", 32'(mem_req_out), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_req",   32'(mem_req_out), 32'd0);
        chk("mrst_ready", 32'(ready_out), 32'd0);
        chk("mrst_addr",  mem_addr_out, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("mrst_ready_back", 32'(ready_out), 32'd1);
        chk("mrst_no_req", 32'(mem_req_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
